// File: rtl/riot_pia.sv
// +--------------------------------------------------------------------------+
// | riot_pia : parametrised PIA with NUM_PORTS I/O ports and interval timer  |
// | Optional edge IRQ on port 0 top bit: define RIOT_PIA_EDGE_IRQ_EN         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module riot_pia #(
  parameter int NUM_PORTS = 2,
  parameter int DAT_W     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       tick_i,
  input  logic                       stb_i,
  input  logic                       we_i,
  input  logic [6:0]                 adr_i,
  input  logic [DAT_W-1:0]           dat_i,
  output logic [DAT_W-1:0]           dat_o,
  input  logic [NUM_PORTS*DAT_W-1:0] port_in_i,
  output logic [NUM_PORTS*DAT_W-1:0] port_out_o,
  output logic [NUM_PORTS*DAT_W-1:0] port_oe_o,
  output logic                       irq_o
);

  localparam logic [6:0] c_ADR_INTIM  = 7'h08;
  localparam logic [6:0] c_ADR_INSTAT = 7'h09;
  localparam logic [6:0] c_ADR_EDGE   = 7'h0A;

  typedef enum logic {ST_NORMAL = 1'b0, ST_UNDERFLOW = 1'b1} mode_t;

  logic [DAT_W-1:0]           r_dat;
  logic [NUM_PORTS*DAT_W-1:0] r_port_out;
  logic [NUM_PORTS*DAT_W-1:0] r_port_oe;
  logic [DAT_W-1:0]           r_intim;
  logic [9:0]                 r_presc;
  logic [1:0]                 r_ivl;
  logic                       r_tim_ie;
  logic                       r_tim_flag;
  logic                       r_irq;
  mode_t                      r_mode;

  logic                       w_rd;
  logic                       w_wr;
  logic                       w_tim_wr;
  logic [9:0]                 w_presc_max;
  logic                       w_step;
  logic                       w_wrap;
  logic [DAT_W-1:0]           w_rdata;
  logic                       w_edge_flag;
  logic                       w_edge_irq;
  logic [DAT_W-1:0]           w_edge_ctl;

  assign w_rd     = stb_i & ~we_i;
  assign w_wr     = stb_i & we_i;
  // 0x14..0x17 and 0x1C..0x1F: adr[3] selects tim_ie, adr[1:0] the interval
  assign w_tim_wr = w_wr & (adr_i[6:4] == 3'b001) & adr_i[2];

  always_comb begin
    case (r_ivl)
      2'd0:    w_presc_max = 10'd0;
      2'd1:    w_presc_max = 10'd7;
      2'd2:    w_presc_max = 10'd63;
      default: w_presc_max = 10'd1023;
    endcase
  end

  assign w_step = tick_i & ((r_mode == ST_UNDERFLOW) | (r_presc == w_presc_max));
  assign w_wrap = w_step & (r_intim == '0);

`ifdef RIOT_PIA_EDGE_IRQ_EN
  logic r_pin_d;
  logic r_edge_flag;
  logic r_edge_pol;
  logic r_edge_ie;
  logic w_edge_evt;

  assign w_edge_evt = r_edge_pol ? (port_in_i[DAT_W-1] & ~r_pin_d)
                                 : (~port_in_i[DAT_W-1] & r_pin_d);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pin_d     <= 1'b0;
      r_edge_flag <= 1'b0;
      r_edge_pol  <= 1'b0;
      r_edge_ie   <= 1'b0;
    end else begin
      r_pin_d <= port_in_i[DAT_W-1];
      if (w_wr && adr_i == c_ADR_EDGE) begin
        r_edge_pol <= dat_i[0];
        r_edge_ie  <= dat_i[1];
      end
      if (w_edge_evt)
        r_edge_flag <= 1'b1;
      else if (w_rd && adr_i == c_ADR_INSTAT)
        r_edge_flag <= 1'b0;
    end
  end

  assign w_edge_flag = r_edge_flag;
  assign w_edge_irq  = r_edge_flag & r_edge_ie;
  assign w_edge_ctl  = {{(DAT_W-2){1'b0}}, r_edge_ie, r_edge_pol};
`else
  assign w_edge_flag = 1'b0;
  assign w_edge_irq  = 1'b0;
  assign w_edge_ctl  = '0;
`endif

  always_comb begin
    w_rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (adr_i[6:3] == 4'd0 && int'(adr_i[2:1]) == p)
        w_rdata = adr_i[0] ? r_port_oe[p*DAT_W +: DAT_W]
                           : (r_port_out[p*DAT_W +: DAT_W] & r_port_oe[p*DAT_W +: DAT_W])
                           | (port_in_i[p*DAT_W +: DAT_W] & ~r_port_oe[p*DAT_W +: DAT_W]);
    end
    case (adr_i)
      c_ADR_INTIM:  w_rdata = r_intim;
      c_ADR_INSTAT: w_rdata = {r_tim_flag, w_edge_flag, {(DAT_W-2){1'b0}}};
      c_ADR_EDGE:   w_rdata = w_edge_ctl;
      default:      ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dat      <= '0;
      r_port_out <= '0;
      r_port_oe  <= '0;
    end else begin
      if (w_rd)
        r_dat <= w_rdata;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_wr && adr_i[6:3] == 4'd0 && int'(adr_i[2:1]) == p) begin
          if (adr_i[0])
            r_port_oe[p*DAT_W +: DAT_W] <= dat_i;
          else
            r_port_out[p*DAT_W +: DAT_W] <= dat_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_intim    <= '0;
      r_presc    <= '0;
      r_ivl      <= 2'd0;
      r_tim_ie   <= 1'b0;
      r_tim_flag <= 1'b0;
      r_mode     <= ST_NORMAL;
    end else if (w_tim_wr) begin
      // a load overrides any tick or underflow in the same cycle
      r_intim    <= dat_i;
      r_presc    <= '0;
      r_ivl      <= adr_i[1:0];
      r_tim_ie   <= adr_i[3];
      r_tim_flag <= 1'b0;
      r_mode     <= ST_NORMAL;
    end else begin
      if (w_step)
        r_intim <= r_intim - DAT_W'(1);
      if (tick_i && r_mode == ST_NORMAL)
        r_presc <= (r_presc == w_presc_max) ? 10'd0 : r_presc + 10'd1;
      if (w_wrap) begin
        r_tim_flag <= 1'b1;
        r_mode     <= ST_UNDERFLOW;
      end else if (w_rd && adr_i == c_ADR_INTIM) begin
        r_tim_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_irq <= 1'b0;
    else
      r_irq <= (r_tim_flag & r_tim_ie) | w_edge_irq;
  end

  assign dat_o      = r_dat;
  assign port_out_o = r_port_out;
  assign port_oe_o  = r_port_oe;
  assign irq_o      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_riot_pia.sv
// +--------------------------------------------------------------------------+
// | tb_riot_pia : directed self-checking bench for riot_pia                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_riot_pia;

  localparam int NP = 2;
  localparam int DW = 8;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             tick_i;
  logic             stb_i;
  logic             we_i;
  logic [6:0]       adr_i;
  logic [DW-1:0]    dat_i;
  logic [DW-1:0]    dat_o;
  logic [NP*DW-1:0] port_in_i;
  logic [NP*DW-1:0] port_out_o;
  logic [NP*DW-1:0] port_oe_o;
  logic             irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  riot_pia #(.NUM_PORTS(NP), .DAT_W(DW)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .tick_i     (tick_i),
    .stb_i      (stb_i),
    .we_i       (we_i),
    .adr_i      (adr_i),
    .dat_i      (dat_i),
    .dat_o      (dat_o),
    .port_in_i  (port_in_i),
    .port_out_o (port_out_o),
    .port_oe_o  (port_oe_o),
    .irq_o      (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic wr(input logic [6:0] a, input logic [DW-1:0] d);
    stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = d;
    @(posedge clk_i);
    @(negedge clk_i);
    stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a);
    stb_i = 1'b1; we_i = 1'b0; adr_i = a;
    @(posedge clk_i);
    @(negedge clk_i);
    stb_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0; tick_i = 1'b1; stb_i = 1'b0; we_i = 1'b0;
    adr_i = '0; dat_i = '0; port_in_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_dat", dat_o, 8'h00);
    check("rst_oe", port_oe_o, 16'h0000);
    check("rst_out", port_out_o, 16'h0000);
    check("rst_irq", irq_o, 1'b0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // port mixing
    port_in_i = {8'hC3, 8'h3C};
    wr(7'h01, 8'hF0);
    wr(7'h00, 8'hA5);
    rd(7'h00);
    check("port0_mix", dat_o, 8'hAC);
    check("port0_out", port_out_o[7:0], 8'hA5);
    check("port0_oe", port_oe_o[7:0], 8'hF0);
    wr(7'h03, 8'h0F);
    wr(7'h02, 8'h5A);
    rd(7'h02);
    check("port1_mix", dat_o, 8'hCA);
    rd(7'h03);
    check("port1_ddr", dat_o, 8'h0F);
    wr(7'h04, 8'hFF);
    rd(7'h04);
    check("unmapped_port2", dat_o, 8'h00);

    // 8T timer with interrupt enabled
    wr(7'h1D, 8'h02);
    rd(7'h08);
    check("t8_intim_2", dat_o, 8'h02);
    idle(7);
    rd(7'h08);
    check("t8_intim_1", dat_o, 8'h01);
    idle(7);
    rd(7'h08);
    check("t8_intim_0", dat_o, 8'h00);
    idle(7);
    check("t8_irq_before", irq_o, 1'b0);
    rd(7'h09);
    check("t8_instat", dat_o, 8'h80);
    check("t8_irq_set", irq_o, 1'b1);
    rd(7'h08);
    check("t8_intim_fe", dat_o, 8'hFE);
    check("t8_irq_hold", irq_o, 1'b1);
    rd(7'h08);
    check("t8_intim_fd", dat_o, 8'hFD);
    check("t8_irq_clr", irq_o, 1'b0);

    // masked timer, read on the underflow edge
    wr(7'h15, 8'h02);
    idle(23);
    rd(7'h08);
    check("mask_intim_pre", dat_o, 8'h00);
    rd(7'h09);
    check("mask_instat", dat_o, 8'h80);
    check("mask_irq", irq_o, 1'b0);
    rd(7'h08);
    check("mask_intim_fe", dat_o, 8'hFE);
    check("mask_irq2", irq_o, 1'b0);

    // timer load colliding with an underflow
    wr(7'h14, 8'h01);
    idle(1);
    wr(7'h15, 8'h33);
    rd(7'h09);
    check("coll_instat", dat_o, 8'h00);
    rd(7'h08);
    check("coll_intim_a", dat_o, 8'h33);
    rd(7'h08);
    check("coll_intim_b", dat_o, 8'h33);

`ifdef RIOT_PIA_EDGE_IRQ_EN
    wr(7'h0A, 8'h03);
    rd(7'h0A);
    check("edge_ctl", dat_o, 8'h03);
    port_in_i[7] = 1'b1;
    idle(1);
    rd(7'h09);
    check("edge_instat", dat_o, 8'h40);
    check("edge_irq", irq_o, 1'b1);
    rd(7'h09);
    check("edge_instat_clr", dat_o, 8'h00);
    check("edge_irq_clr", irq_o, 1'b0);
    port_in_i[7] = 1'b0;
    idle(2);
    rd(7'h09);
    check("edge_fall", dat_o, 8'h00);
    check("edge_fall_irq", irq_o, 1'b0);
`else
    wr(7'h0A, 8'h03);
    rd(7'h0A);
    check("edge_ctl_absent", dat_o, 8'h00);
    port_in_i[7] = 1'b1;
    idle(2);
    rd(7'h09);
    check("edge_absent_instat", dat_o, 8'h00);
    check("edge_absent_irq", irq_o, 1'b0);
    port_in_i[7] = 1'b0;
`endif

    // asynchronous reset mid-count
    rd(7'h00);
    check("pre_rst_read", dat_o, 8'hAC);
    rst_ni = 1'b0;
    #1;
    check("arst_dat", dat_o, 8'h00);
    check("arst_oe", port_oe_o, 16'h0000);
    check("arst_out", port_out_o, 16'h0000);
    check("arst_irq", irq_o, 1'b0);
    tick_i = 1'b0;
    port_in_i = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    for (int a = 0; a < 11; a++) begin
      if (a < 4 || a > 7) begin
        rd(7'(a));
        check($sformatf("post_rst_rd_%0h", a), dat_o, 8'h00);
      end
    end
    check("post_rst_irq", irq_o, 1'b0);
    check("post_rst_oe", port_oe_o, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
